display_scanner: RTL
====================

// Module: display_scanner
// PURPOSE
// Time-multiplexed driver for the calculator's physical display. Snapshots the
// display register value (calc_pkg::num_t) once per frame and scans it digit by
// digit onto a shared 7-segment bus with per-digit anode enables.
// Sits beside the display register, parallel to the input controller. Read-only
// on the display register; never writes it.
// PARAMETERS
// ClkDiv        50000  clk cycles per digit slot (blank + drive); must be > BlankCycles
// BlankCycles   8      cycles per slot with all anodes off (anti-ghosting)
// SegActiveLow  1      1: seg_o/dp_o/an_o active-low; 0: active-high
// (digit count is calc_pkg::NumDigits, not a parameter)
// PORTS
// clk_i       in   1          clock
// rst_ni      in   1          async reset, active-low
// enable_i    in   1          0: blank all outputs, hold scan position
// lamp_test_i in   1          1: every segment and dp lit on every digit
// display_i   in   num_t      display register read data (display_rdata)
// seg_o       out  7          {g,f,e,d,c,b,a} for the current digit
// dp_o        out  1          decimal point for the current digit
// an_o        out  NumDigits  one-hot digit enable; an_o[0] = leftmost digit
// frame_o     out  1          1-cycle pulse when a new snapshot is taken
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low (rst_ni).
// - Reset (asserted at any time, mid-slot included): outputs go inactive at once
//   (all anodes, segments and dp off at the configured polarity); frame_o=0;
//   state=S_LOAD; digit_idx=0; slot_cnt=0; snapshot=0.
// - FSM: S_LOAD -> S_BLANK -> S_DRIVE -> (S_BLANK if digit_idx<NumDigits-1,
//   otherwise S_LOAD)
//   S_LOAD: 1 cycle. snapshot<=display_i, frame_o=1, digit_idx<=0, outputs off
//   S_BLANK: BlankCycles cycles, anodes off
//   S_DRIVE: ClkDiv-BlankCycles cycles, an_o[digit_idx] active. On exit,
//            digit_idx++ with no wrap
// - Frame period: 1 + NumDigits*ClkDiv cycles. display_i changes mid-frame have
//   no effect until the next S_LOAD (no tearing).
// - Digit mapping: position p shows snapshot.significand[NumDigits-1-p] (BCD).
//   The decimal point is lit at p == snapshot.exponent.
// - Trailing-zero blanking: position p blanks (seg off) when p > exponent and
//   every significand digit at positions >= p is 0. Position 0 never blanks, so
//   zero displays as "0.".
// - Overflow: exponent >= NumDigits gives 'E' at position 0, all other
//   positions blank, no dp.
// - Invalid BCD digit (>9) shows segment g only ("-").
// - Glyphs (active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//   E=79 -=40. Invert all outputs when SegActiveLow=1.
// - lamp_test_i overrides glyph and dp (all on) but not the anode timing.
//   enable_i=0 overrides lamp_test_i.
// - enable_i=0: outputs inactive from the same cycle, slot_cnt/digit_idx/state
//   frozen, frame_o=0. Scanning resumes exactly where it stopped.
// - Outputs registered: seg_o/dp_o/an_o/frame_o reflect state with 1-cycle latency.
// - At most one an_o bit is active in any cycle. Never active during S_BLANK/S_LOAD.
// TESTING (bench: NumDigits=4, ClkDiv=10, BlankCycles=2, SegActiveLow=0)
// 1. Release reset, display_i=sig{1,2,3,0} exp=1 -> frame_o every 41 cycles;
//    digits 06,5B+dp,4F,blank; an_o active 8 cycles per slot, 2 off.
// 2. display_i=0 -> position 0 = 3F with dp, positions 1-3 blank every frame.
// 3. display_i exp=5 -> an_o[0] shows 79, no dp; positions 1-3 blank.
// 4. Change display_i mid-frame -> old value held until next frame_o, new after.
// 5. enable_i low 7 cycles in S_DRIVE of digit 2 -> outputs off; resumes with
//    remaining slot count unchanged. lamp_test_i=1 -> 7F+dp on each digit.
// 6. Assert rst_ni mid-S_DRIVE (async, between edges) -> an_o=0 immediately;
//    after release, S_LOAD first, frame_o on the first active edge.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : calc_pkg
// Description : Shared calculator types. num_t is the display register
//               format: a BCD significand (significand[NumDigits-1] is the
//               leftmost digit) plus the decimal-point position (exponent).
//               An exponent >= NumDigits marks an overflowed value.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

  localparam int NumDigits = 4;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t [NumDigits-1:0] significand;
    logic [3:0]           exponent;
  } num_t;

endpackage
`default_nettype wire

// File: rtl/display_scanner_if.sv
`default_nettype none
// ============================================================================
// Interface   : display_scanner_if
// Description : Control inputs and multiplexed display outputs of the
//               display scanner.
//   enable_i    : 0 blanks all outputs and freezes the scan position
//   lamp_test_i : 1 lights every segment and dp on every digit
//   display_i   : display register read data
//   seg_o       : {g,f,e,d,c,b,a} for the digit currently enabled
//   dp_o        : decimal point for the digit currently enabled
//   an_o        : one-hot digit enable, an_o[0] = leftmost digit
//   frame_o     : 1-cycle pulse when a new snapshot is taken
//   master = controller/bench side, slave = scanner side
// Revision    : 1.0 - initial release
// ============================================================================
interface display_scanner_if;

  logic                           enable_i;
  logic                           lamp_test_i;
  calc_pkg::num_t                 display_i;
  logic [6:0]                     seg_o;
  logic                           dp_o;
  logic [calc_pkg::NumDigits-1:0] an_o;
  logic                           frame_o;

  modport master (
    output enable_i, lamp_test_i, display_i,
    input  seg_o, dp_o, an_o, frame_o
  );

  modport slave (
    input  enable_i, lamp_test_i, display_i,
    output seg_o, dp_o, an_o, frame_o
  );

endinterface
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : display_scanner
// Description : Time-multiplexed 7-segment display driver. Takes a snapshot
//               of the display register once per frame, then scans it one
//               digit per slot. Each slot starts with BlankCycles of all
//               anodes off (anti-ghosting), then drives one anode for the rest
//               of the slot. Frame = 1 load cycle + NumDigits slots.
// Ports       : clk_i  - clock
//               rst_ni - asynchronous reset, active-low
//               bus    - display_scanner_if.slave (enable, lamp test, display
//                        data in; seg/dp/anode/frame out)
// Parameters  : ClkDiv       - cycles per digit slot (must exceed BlankCycles)
//               BlankCycles  - anodes-off cycles at the start of each slot
//               SegActiveLow - 1: seg/dp/an active-low, 0: active-high
// Revision    : 1.0 - initial release
// ============================================================================
module display_scanner
  import calc_pkg::*;
#(
  parameter int ClkDiv       = 50000,
  parameter int BlankCycles  = 8,
  parameter bit SegActiveLow = 1'b1
) (
  input  wire logic     clk_i,
  input  wire logic     rst_ni,
  display_scanner_if.slave bus
);

  localparam int c_cnt_w = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  // One spare bit so the index can step past the last digit without wrapping
  localparam int c_idx_w = $clog2(NumDigits + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(ClkDiv - 1);
  localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BlankCycles - 1);
  localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(NumDigits - 1);
  localparam logic [NumDigits-1:0] c_an_one   = NumDigits'(1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_idx_w-1:0]   r_digit_idx;
  logic [c_cnt_w-1:0]   r_slot_cnt;
  num_t                 r_snapshot;

  // Registered outputs, held active-high internally
  logic [6:0]           r_seg;
  logic                 r_dp;
  logic [NumDigits-1:0] r_an;
  logic                 r_frame;

  logic [6:0]           w_seg;
  logic                 w_dp;
  logic [NumDigits-1:0] w_an;
  logic [3:0]           w_digit;
  logic                 w_tail_zero;

  function automatic logic [6:0] f_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h40;  // invalid BCD shows "-"
    endcase
    return g;
  endfunction

  // Glyph for the digit at the current scan position. Position p shows
  // significand[NumDigits-1-p]; w_tail_zero is set when that digit and every
  // digit to its right are zero, which drives trailing-zero blanking.
  always_comb begin
    w_digit     = 4'd0;
    w_tail_zero = 1'b1;
    for (int q = 0; q < NumDigits; q++) begin
      if (q == int'(r_digit_idx)) begin
        w_digit = r_snapshot.significand[NumDigits-1-q];
      end
      if ((q >= int'(r_digit_idx)) &&
          (r_snapshot.significand[NumDigits-1-q] != 4'd0)) begin
        w_tail_zero = 1'b0;
      end
    end

    w_an  = '0;
    w_seg = 7'h00;
    w_dp  = 1'b0;
    if (r_state == S_DRIVE) begin
      w_an = c_an_one << r_digit_idx;
      if (bus.lamp_test_i) begin
        w_seg = 7'h7F;
        w_dp  = 1'b1;
      end else if (int'(r_snapshot.exponent) >= NumDigits) begin
        w_seg = (r_digit_idx == '0) ? 7'h79 : 7'h00;
      end else begin
        w_dp  = (int'(r_snapshot.exponent) == int'(r_digit_idx));
        // p > exponent implies p >= 1, so the leftmost digit never blanks
        if ((int'(r_digit_idx) > int'(r_snapshot.exponent)) && w_tail_zero) begin
          w_seg = 7'h00;
        end else begin
          w_seg = f_glyph(w_digit);
        end
      end
    end
  end

  // Scan FSM with registered outputs. While disabled, all scan state and the
  // output registers hold, so the scan picks up exactly where it paused.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_LOAD;
      r_digit_idx <= '0;
      r_slot_cnt  <= '0;
      r_snapshot  <= '0;
      r_seg       <= 7'h00;
      r_dp        <= 1'b0;
      r_an        <= '0;
      r_frame     <= 1'b0;
    end else if (bus.enable_i) begin
      r_seg   <= w_seg;
      r_dp    <= w_dp;
      r_an    <= w_an;
      r_frame <= (r_state == S_LOAD);
      case (r_state)
        S_LOAD: begin
          r_snapshot  <= bus.display_i;
          r_digit_idx <= '0;
          r_slot_cnt  <= '0;
          r_state     <= S_BLANK;
        end
        S_BLANK: begin
          // slot_cnt runs across the whole slot; blank covers its first part
          if (r_slot_cnt == c_blank_last) begin
            r_state <= S_DRIVE;
          end
          r_slot_cnt <= r_slot_cnt + 1'b1;
        end
        S_DRIVE: begin
          if (r_slot_cnt == c_cnt_last) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= r_digit_idx + 1'b1;
            r_state     <= (r_digit_idx == c_idx_last) ? S_LOAD : S_BLANK;
          end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end else begin
      r_frame <= 1'b0;
    end
  end

  // Disable blanks the pins in the same cycle; polarity applied at the pins
  assign bus.seg_o   = bus.enable_i ? (r_seg ^ {7{SegActiveLow}}) : {7{SegActiveLow}};
  assign bus.dp_o    = bus.enable_i ? (r_dp ^ SegActiveLow) : SegActiveLow;
  assign bus.an_o    = bus.enable_i ? (r_an ^ {NumDigits{SegActiveLow}})
                                    : {NumDigits{SegActiveLow}};
  assign bus.frame_o = bus.enable_i & r_frame;

endmodule
`default_nettype wire
